ssd_scan: RTL and testbench
===========================

# ssd_scan

Four-digit multiplexed seven-segment driver that sits directly downstream of the PS/2 receiver. It consumes the receiver's four 4-bit scan-code nibbles and displays them as hex on a common-anode display, one digit per time slot. Inputs are snapshotted once per frame so a mid-frame update never shows a torn value. A decimal point flags a value change for a programmable number of frames.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 500: dead time at the start of each slot with all anodes off; must be < REFRESH_DIV; 0 allowed.
- FRESH_FRAMES, 8: number of frames the change indicator stays lit after a value change; range 1–255.
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- data1  input  4  digit 0 (rightmost), low nibble of the newest scan byte.
- data2  input  4  digit 1.
- data3  input  4  digit 2.
- data4  input  4  digit 3 (leftmost).
- an  output  4  digit anodes, active-low; an[k] enables digit k.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation
- Slot counter `cnt` runs 0..REFRESH_DIV-1 and wraps.
- Digit index `idx` runs 0..3 and advances when `cnt` wraps; 3 wraps to 0.
- A frame is slots 0..3, which is 4·REFRESH_DIV cycles.
- **Snapshot:** in the cycle where cnt==REFRESH_DIV-1 and idx==3, all four inputs are captured into a 16-bit shadow register. The previous shadow value is kept for comparison.
- **Change detect:** if the new snapshot differs from the old one, the fresh counter loads FRESH_FRAMES. Otherwise it decrements at each snapshot, saturating at 0.
- **Digit output, blank phase (cnt < BLANK_CYCLES):**
  - an = 4'b1111.
  - seg = 7'b1111111.
  - dp = 1.
- **Digit output, active phase:**
  - an = ~(4'b0001 << idx).
  - seg = hex decode of shadow nibble idx.
  - dp = 0 only when idx==0 and the fresh counter ≠ 0; otherwise dp = 1.
- **Hex decode, active-low, gfedcba:**
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- **States:** slot position (cnt, idx) is the only control state; no handshake exists. The inputs are level signals and are sampled only at snapshot.

## Timing
- **Registered outputs:** an, seg and dp are registered. The outputs in cycle t reflect cnt/idx/shadow as they were in cycle t-1.
- **Reset values:**
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - cnt = 0, idx = 0.
  - Both shadow registers = 16'h0000; fresh counter = 0.
- **First frame after reset:** the display shows "0000". The first snapshot occurs at cycle 4·REFRESH_DIV-1 after reset release.
- **Input latency:** a change is visible no earlier than the first active cycle of the next frame. The worst case is 4·REFRESH_DIV + BLANK_CYCLES + 1 cycles.
- **Input changing in the snapshot cycle:** the value present in that cycle is the one captured.
- **Reset asserted mid-slot:** every register returns to its reset value on the next clock edge. The outputs are blank in the following cycle.
- **BLANK_CYCLES = 0:** no blank phase; the anode switches directly between digits.

## Configuration
- **SSD_LEADING_ZERO_BLANK_EN defined:** during the active phase of digits 3, 2 and 1, the anode stays off if that digit and every digit to its left are zero in the shadow register. Digit 0 is always shown.
- **Not defined:** all four digits are always shown, including leading zeros.

## Structure
- **Package `ssd_pkg`:**
  - the segment-pattern constants for 0–F, plus SEG_OFF = 7'b1111111 and AN_OFF = 4'b1111;
  - the hex-to-segment function.
- **Sub-module `hex7seg`:** purely combinational; 4-bit in, 7-bit out; instantiated once on the muxed nibble.

## Test plan
Bench parameters for all scenarios: REFRESH_DIV=8, BLANK_CYCLES=2, FRESH_FRAMES=2.

- **Reset:** hold rst for 3 cycles. Required: an=1111, seg=1111111 and dp=1 during reset. In the first active cycle, an=1110 and seg=1000000.
- **Digit scan:** inputs data4..1 = F,0,A,5. Required for frame 2:
  - slot 0: an=1110, seg=0010010;
  - slot 1: an=1101, seg=0001000;
  - slot 2: an=1011, seg=1000000;
  - slot 3: an=0111, seg=0001110;
  - each slot blank for 2 cycles.
- **Tear-free snapshot:** change data1 from 3 to 7 in the middle of slot 2. Required: slot 0 of the current frame kept showing 3; 7 appears only in slot 0 of the next frame.
- **Change indicator:** change data2 once. Required: dp=0 during slot-0 active cycles for exactly 2 frames, then dp=1.
- **SSD_LEADING_ZERO_BLANK_EN:** inputs 0,0,4,0 (data4..1), macro defined. Required: an=1111 in slots 3 and 2; digits 1 and 0 lit. Without the macro, all four digits are lit.
- **Mid-frame reset:** assert rst in slot 2 with a non-zero display. Required: outputs blank the next cycle; cnt=0, idx=0 and the display reads 0000 after release.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: active-low gfedcba segment patterns, blanking constants and hex decode.
package ssd_pkg;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [15:0][6:0] SEG_HEX = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                            SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        return SEG_HEX[n];
    endfunction
endpackage

// File: rtl/ssd_scan_if.sv
// ssd_scan_if: scan-code nibbles in, multiplexed anode/segment/dp drive out.
interface ssd_scan_if;
    logic [3:0] data1;
    logic [3:0] data2;
    logic [3:0] data3;
    logic [3:0] data4;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    modport master (output data1, data2, data3, data4, input an, seg, dp);
    modport slave (input data1, data2, data3, data4, output an, seg, dp);
endinterface

// File: rtl/ssd_scan_hex7seg.sv
// hex7seg: combinational nibble to active-low seven-segment decoder.
module hex7seg
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb seg = hex_to_seg(nib);
endmodule

// File: rtl/ssd_scan.sv
// ssd_scan: four-digit multiplexed hex display with per-frame snapshot and change indicator.
// Optional SSD_LEADING_ZERO_BLANK_EN turns off anodes of leading zero digits.
module ssd_scan
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int FRESH_FRAMES = 8
) (
    input logic   clk,
    input logic   rst,
    ssd_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d, sample;
    logic [7:0]    fresh_q, fresh_d;
    logic [3:0]    an_q, an_d, nib;
    logic [6:0]    seg_q, seg_d, seg_dec;
    logic          dp_q, dp_d, wrap, snap, blank, hide;

    hex7seg u_hex (.nib(nib), .seg(seg_dec));

    always_comb begin
        wrap     = cnt_q == CW'(REFRESH_DIV - 1);
        snap     = wrap && idx_q == 2'd3;
        sample   = {bus.data4, bus.data3, bus.data2, bus.data1};
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? idx_q + 2'd1 : idx_q;
        shadow_d = snap ? sample : shadow_q;
        // the shadow still holds the previous frame's value when the new one is sampled
        fresh_d  = !snap ? fresh_q
                 : sample != shadow_q ? 8'(FRESH_FRAMES)
                 : fresh_q == 8'd0 ? 8'd0 : fresh_q - 8'd1;
        nib      = shadow_q[{idx_q, 2'b00} +: 4];
        blank    = int'(cnt_q) < BLANK_CYCLES;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        hide     = idx_q != 2'd0 && (shadow_q >> {idx_q, 2'b00}) == 16'h0000;
`else
        hide     = 1'b0;
`endif
        an_d     = blank || hide ? AN_OFF : ~(4'b0001 << idx_q);
        seg_d    = blank ? SEG_OFF : seg_dec;
        dp_d     = blank || idx_q != 2'd0 || fresh_q == 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 16'h0000;
            fresh_q  <= 8'd0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            fresh_q  <= fresh_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_ssd_scan.sv
// tb_ssd_scan: directed and random scan checks against a frame-level display model.
module tb_ssd_scan;
    localparam int R = 8, B = 2, F = 2, FR = 4 * R;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ssd_scan_if bus ();
    ssd_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .FRESH_FRAMES(F)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int t = 0;
    int m_fresh = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [6:0] hex [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic set_data(input logic [15:0] v);
        {bus.data4, bus.data3, bus.data2, bus.data1} = v;
    endtask

    // model: slot position is just elapsed cycles since reset release
    task automatic tick(input string tag);
        logic [3:0] ea;
        logic [6:0] es;
        logic ed;
        logic [15:0] nw;
        int c, k;
        c = t % R;
        k = (t / R) % 4;
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
        if (!rst && c >= B) begin
            ea = ~(4'b0001 << k);
            es = hex[m_shadow[4*k +: 4]];
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (k != 0 && (m_shadow >> (4 * k)) == 16'h0000) ea = 4'hF;
`endif
            ed = !(k == 0 && m_fresh != 0);
        end
        @(posedge clk);
        if (rst) begin
            t = 0; m_shadow = 16'h0000; m_fresh = 0;
        end else begin
            if (t % FR == FR - 1) begin
                nw = {bus.data4, bus.data3, bus.data2, bus.data1};
                m_fresh = nw != m_shadow ? F : (m_fresh > 0 ? m_fresh - 1 : 0);
                m_shadow = nw;
            end
            t++;
        end
        #1;
        chk({tag, " an"}, {3'b000, bus.an}, {3'b000, ea});
        chk({tag, " seg"}, bus.seg, es);
        chk({tag, " dp"}, {6'd0, bus.dp}, {6'd0, ed});
    endtask

    task automatic run(input string tag, input int n);
        repeat (n) tick(tag);
    endtask

    task automatic run_to(input string tag, input int pos);
        for (int i = 0; i < FR && t % FR != pos; i++) tick(tag);
    endtask

    initial begin
        logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_exp [4] = '{7'b0010010, 7'b0001000, 7'b1000000, 7'b0001110};
        int lit;
        set_data(16'h0000);
        run("reset", 3);
        rst = 1'b0;
        run_to("first", B + 1);
        chk("first_active an", {3'b000, bus.an}, 7'b0001110);
        chk("first_active seg", bus.seg, 7'b1000000);

        set_data(16'hF0A5);
        for (int s = 0; s < 4; s++) begin
            while (t < FR + s * R + B + 1) tick("scan");
            chk("scan_slot an", {3'b000, bus.an}, {3'b000, an_exp[s]});
            chk("scan_slot seg", bus.seg, seg_exp[s]);
        end
        run("scan", 2 * FR);

        set_data(16'hF0A3);
        run("tear", FR);
        run_to("tear", 2 * R + 4);
        set_data(16'hF0A7);
        run_to("tear", 0);
        run_to("tear", B + 1);
        chk("tear_new seg", bus.seg, 7'b1111000);

        run("settle", 3 * FR);
        run_to("fresh", FR - 3);
        set_data(16'hF0B7);
        lit = 0;
        for (int i = 0; i < 5 * FR; i++) begin
            tick("fresh");
            if (bus.dp === 1'b0) lit++;
        end
        chk("fresh_count", 7'(lit), 7'(2 * (R - B)));

        for (int i = 0; i < 12 * FR; i++) begin
            if ($urandom_range(7) == 0) set_data(16'($urandom));
            tick("random");
        end

        set_data(16'h0040);
        run("lz", FR);
        run_to("lz", 0);
        run_to("lz", 3 * R + B + 1);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        chk("lz_slot3 an", {3'b000, bus.an}, 7'b0001111);
`else
        chk("lz_slot3 an", {3'b000, bus.an}, 7'b0000111);
`endif
        run_to("lz", R + B + 1);
        chk("lz_slot1 an", {3'b000, bus.an}, 7'b0001101);

        set_data(16'h1234);
        run("mid", 2 * FR);
        run_to("mid", 2 * R + 3);
        rst = 1'b1;
        tick("mid_rst");
        chk("mid_rst an", {3'b000, bus.an}, 7'b0001111);
        rst = 1'b0;
        run_to("mid_after", B + 1);
        chk("mid_after an", {3'b000, bus.an}, 7'b0001110);
        chk("mid_after seg", bus.seg, 7'b1000000);
        run("mid_after", 2 * FR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
